// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: NPAR neurons accumulate n_in beats of
// in_data*w_data on top of a bias, then saturate/ReLU into out_data.
// Ports: start/n_in/relu_en/bias begin a pass; in_valid/in_ready carry the
// input beats (in_data, w_data); out_valid/out_ready return out_data and
// argmax; busy is high outside IDLE; err pulses on a rejected start.
// Optional macro MLP_ARGMAX_EN builds the argmax comparator tree.
module mlp_layer_engine #(
  parameter int DW      = 8,
  parameter int NPAR    = 10,
  parameter int NIN_MAX = 62,
  parameter int ACCW    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          n_in,
  input  logic                 relu_en,
  input  logic [NPAR*DW-1:0]   bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [NPAR*DW-1:0]   w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NPAR*DW-1:0]   out_data,
  output logic [7:0]           argmax,
  output logic                 busy,
  output logic                 err
);

  localparam int ACCW_MIN = 2*DW + $clog2(NIN_MAX+1) + 1;

  if (ACCW < ACCW_MIN) begin : g_accw_chk
    $error("mlp_layer_engine: ACCW too small");
  end

  localparam logic signed [ACCW-1:0] SAT_HI =
    {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO =
    {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_ACC, S_ACT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         nin_q, nin_d;
  logic                relu_q, relu_d;
  logic                err_q, err_d;
  logic [NPAR*DW-1:0]  out_q, out_d;
  logic signed [ACCW-1:0] acc_q [NPAR];
  logic signed [ACCW-1:0] acc_d [NPAR];
  logic signed [ACCW-1:0] prod  [NPAR];
  logic signed [ACCW-1:0] bext  [NPAR];
  logic [NPAR*DW-1:0]  act_pk;

`ifdef MLP_ARGMAX_EN
  logic signed [DW-1:0] act [NPAR];
  logic [7:0]           amax_q, amax_d, amax_c;
`endif

  for (genvar k = 0; k < NPAR; k++) begin : g_n
    logic signed [DW-1:0]   w_k, b_k, a_k;
    logic signed [2*DW-1:0] p_k;
    logic signed [ACCW-1:0] r_k;

    assign w_k = w_data[k*DW +: DW];
    assign b_k = bias[k*DW +: DW];
    assign p_k = $signed(in_data) * w_k;
    assign prod[k] = {{(ACCW-2*DW){p_k[2*DW-1]}}, p_k};
    // Bias is Q1.(DW-1); products are Q2.(2DW-2), so align by DW-1.
    assign bext[k] = {{(ACCW-DW){b_k[DW-1]}}, b_k} <<< (DW-1);
    assign r_k = acc_q[k] >>> (DW-1);

    always_comb begin
      a_k = r_k[DW-1:0];
      if (r_k > SAT_HI) a_k = SAT_HI[DW-1:0];
      if (r_k < SAT_LO) a_k = SAT_LO[DW-1:0];
      if (relu_q && r_k < 0) a_k = '0;
    end

    assign act_pk[k*DW +: DW] = a_k;
`ifdef MLP_ARGMAX_EN
    assign act[k] = a_k;
`endif
  end

`ifdef MLP_ARGMAX_EN
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    logic signed [DW-1:0] best;
    best   = act[0];
    amax_c = '0;
    for (int k = 1; k < NPAR; k++) begin
      if (act[k] > best) begin
        best   = act[k];
        amax_c = 8'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nin_d   = nin_q;
    relu_d  = relu_q;
    err_d   = 1'b0;
    out_d   = out_q;
    acc_d   = acc_q;
`ifdef MLP_ARGMAX_EN
    amax_d  = amax_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_in == 16'd0 || n_in > 16'(NIN_MAX)) begin
            err_d = 1'b1;
          end else begin
            nin_d   = n_in;
            relu_d  = relu_en;
            cnt_d   = '0;
            acc_d   = bext;
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          for (int k = 0; k < NPAR; k++)
            acc_d[k] = acc_q[k] + prod[k];
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == nin_q) state_d = S_ACT;
        end
      end
      S_ACT: begin
        out_d   = act_pk;
`ifdef MLP_ARGMAX_EN
        amax_d  = amax_c;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nin_q   <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
      for (int k = 0; k < NPAR; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nin_q   <= nin_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
      out_q   <= out_d;
      for (int k = 0; k < NPAR; k++) acc_q[k] <= acc_d[k];
    end
  end

`ifdef MLP_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (rst) amax_q <= '0;
    else     amax_q <= amax_d;
  end
  assign argmax = rst ? 8'd0 : amax_q;
`else
  assign argmax = 8'd0;
`endif

  // Outputs are forced low for the whole time rst is held.
  assign in_ready  = !rst && (state_q == S_ACC);
  assign out_valid = !rst && (state_q == S_DONE);
  assign busy      = !rst && (state_q != S_IDLE);
  assign err       = !rst && err_q;
  assign out_data  = rst ? '0 : out_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Self-checking bench for mlp_layer_engine (default parameters).
// Expected results come from an integer model pushed to a scoreboard.
module tb_mlp_layer_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_in = '0;
  logic        relu_en = 1'b0;
  logic [79:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [79:0] w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] out_data;
  logic [7:0]  argmax;
  logic        busy;
  logic        err;

  mlp_layer_engine dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in),
    .relu_en(relu_en), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .argmax(argmax), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] d;
    logic [7:0]  a;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  din [64];
  logic [79:0] wv  [64];
  logic [79:0] last_out;
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(int n, bit relu, logic [79:0] b);
    exp_t e;
    int best;
    e.d = '0;
    e.a = '0;
    best = -1000;
    for (int k = 0; k < 10; k++) begin
      int acc;
      int r;
      acc = $signed(b[k*8 +: 8]) * 128;
      for (int i = 0; i < n; i++)
        acc += $signed(din[i]) * $signed(wv[i][k*8 +: 8]);
      r = acc >>> 7;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      if (relu && r < 0) r = 0;
      e.d[k*8 +: 8] = 8'(r);
      if (r > best) begin
        best = r;
`ifdef MLP_ARGMAX_EN
        e.a = 8'(k);
`endif
      end
    end
    return e;
  endfunction

  task automatic run_pass(input string nm, input int n, input bit relu,
                          input logic [79:0] b, input bit gap,
                          input int hold, input bit busy_start);
    exp_t e;
    int   i;
    int   cyc;
    bit   rdy;
    bit   err_seen;
    sb.push_back(model(n, relu, b));
    start = 1'b1; n_in = 16'(n); relu_en = relu; bias = b;
    tick();
    start = 1'b0;
    i = 0; cyc = 0; err_seen = 1'b0;
    while (i < n && cyc < 1000) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = din[i];
      w_data   = wv[i];
      if (busy_start) begin
        start = 1'b1; n_in = 16'd0;
      end
      rdy = in_ready;
      tick();
      if (err) err_seen = 1'b1;
      if (in_valid && rdy) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    vectors++;
    if (i != n) begin
      miscompares++;
      $display("FAIL %s beats: accepted %0d required %0d", nm, i, n);
    end
    if (busy_start) begin
      vectors++;
      if (err_seen || err) begin
        miscompares++;
        $display("FAIL %s busy_start_err: got 1 required 0", nm);
      end
    end
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_last: in_ready %b out_valid %b required 0 0",
               nm, in_ready, out_valid);
    end
    tick();
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid_lat: got %b required 1", nm, out_valid);
    end
    vectors++;
    if (out_data !== e.d) begin
      miscompares++;
      $display("FAIL %s out_data: got %h required %h", nm, out_data, e.d);
    end
    vectors++;
    if (argmax !== e.a) begin
      miscompares++;
      $display("FAIL %s argmax: got %0d required %0d", nm, argmax, e.a);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== e.d || argmax !== e.a) begin
        miscompares++;
        $display("FAIL %s hold%0d: valid %b data %h amax %0d required 1 %h %0d",
                 nm, h, out_valid, out_data, argmax, e.d, e.a);
      end
    end
    last_out = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: busy %b out_valid %b required 0 0",
               nm, busy, out_valid);
    end
  endtask

  task automatic fill(input logic [7:0] d, input logic [79:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      din[i] = d;
      wv[i]  = w;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({out_valid, in_ready, busy, err} !== 4'b0 ||
        out_data !== '0 || argmax !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: ov %b ir %b busy %b err %b data %h amax %0d required all 0",
               out_valid, in_ready, busy, err, out_data, argmax);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy %b in_ready %b required 0 0",
               busy, in_ready);
    end
  endtask

  task automatic test_basic();
    fill(8'd64, {10{8'd64}}, 1);
    run_pass("basic", 1, 1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_saturate();
    fill(8'd127, {10{8'd127}}, 4);
    run_pass("saturate", 4, 1'b0, {10{8'd127}}, 1'b0, 0, 1'b0);
  endtask

  task automatic test_negative();
    fill(8'd64, {10{8'hC0}}, 1);
    run_pass("neg_norelu", 1, 1'b0, '0, 1'b0, 0, 1'b0);
    run_pass("neg_relu", 1, 1'b1, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [79:0] b;
    logic [79:0] ref_out;
    for (int i = 0; i < 62; i++) begin
      din[i] = 8'($urandom);
      for (int k = 0; k < 10; k++) wv[i][k*8 +: 8] = 8'($urandom);
    end
    for (int k = 0; k < 10; k++) b[k*8 +: 8] = 8'($urandom);
    run_pass("b2b", 62, 1'b0, b, 1'b0, 0, 1'b0);
    ref_out = last_out;
    run_pass("gapped", 62, 1'b0, b, 1'b1, 0, 1'b1);
    vectors++;
    if (last_out !== ref_out) begin
      miscompares++;
      $display("FAIL gapped_vs_b2b: got %h required %h", last_out, ref_out);
    end
  endtask

  task automatic test_argmax_tie();
    logic [79:0] w;
    w = '0;
    w[3*8 +: 8] = 8'd100;
    w[7*8 +: 8] = 8'd100;
    fill(8'd64, w, 1);
    run_pass("argmax_tie", 1, 1'b0, '0, 1'b0, 5, 1'b0);
  endtask

  task automatic test_err();
    logic [15:0] bad [2];
    bad[0] = 16'd0;
    bad[1] = 16'd63;
    for (int j = 0; j < 2; j++) begin
      start = 1'b1; n_in = bad[j];
      tick();
      start = 1'b0;
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err_pulse n_in=%0d: err %b busy %b required 1 0",
                 bad[j], err, busy);
      end
      tick();
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err_clear n_in=%0d: err %b busy %b required 0 0",
                 bad[j], err, busy);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int i;
    int cyc;
    bit rdy;
    fill(8'd100, {10{8'd50}}, 62);
    start = 1'b1; n_in = 16'd62; relu_en = 1'b0; bias = '0;
    tick();
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 10 && cyc < 100) begin
      in_valid = 1'b1; in_data = din[i]; w_data = wv[i];
      rdy = in_ready;
      tick();
      if (rdy) i++;
      cyc++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, busy, err} !== 4'b0 ||
        out_data !== '0 || argmax !== 8'd0) begin
      miscompares++;
      $display("FAIL midpass_rst: ov %b ir %b busy %b err %b data %h required all 0",
               out_valid, in_ready, busy, err, out_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midpass_idle: busy %b required 0", busy);
    end
    for (int k = 0; k < 5; k++) begin
      din[k] = 8'($urandom);
      wv[k]  = {$urandom, $urandom, $urandom};
    end
    run_pass("after_rst", 5, 1'b1, {10{8'hF0}}, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_back_to_back();
    test_argmax_tie();
    test_err();
    test_reset_midpass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mlp_layer_engine.md
MLP_LAYER_ENGINE -- requirements
Module: mlp_layer_engine

Interface
REQ-001 SHALL have parameter DW, default 8: data, weight and bias width, signed Q1.(DW-1).
REQ-002 SHALL have parameter NPAR, default 10: parallel neurons per pass.
REQ-003 SHALL have parameter NIN_MAX, default 62: maximum inputs per pass.
REQ-004 SHALL have parameter ACCW, default 24: accumulator width; the module SHALL require ACCW >= 2*DW + clog2(NIN_MAX+1) + 1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begin a pass; accepted only in IDLE.
REQ-008 SHALL have port n_in, input, 16: number of input beats for the pass.
REQ-009 SHALL have port relu_en, input, 1: apply ReLU at activation; latched at start.
REQ-010 SHALL have port bias, input, NPAR*DW: per-neuron bias, neuron k at [k*DW +: DW]; sampled at start.
REQ-011 SHALL have port in_valid, input, 1, and port in_ready, output, 1: input-beat handshake.
REQ-012 SHALL have port in_data, input, DW: input activation for the current beat.
REQ-013 SHALL have port w_data, input, NPAR*DW: weights of all neurons for the current beat, same packing as bias.
REQ-014 SHALL have port out_valid, output, 1, and port out_ready, input, 1: result handshake.
REQ-015 SHALL have port out_data, output, NPAR*DW: activated neuron outputs, same packing as bias.
REQ-016 SHALL have port argmax, output, 8: index of the largest out_data element.
REQ-017 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-018 SHALL have port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-019 The FSM SHALL have the states IDLE, ACC, ACT and DONE.
REQ-020 In IDLE, a start with 1 <= n_in <= NIN_MAX SHALL latch n_in and relu_en, load acc[k] = sign-extended bias[k] << (DW-1), clear the beat counter, and go to ACC.
REQ-021 In IDLE, a start with n_in = 0 or n_in > NIN_MAX SHALL pulse err for one cycle and remain in IDLE.
REQ-022 In ACC, in_ready SHALL be 1; on each cycle with in_valid and in_ready high, the engine SHALL perform acc[k] += signed(in_data) * signed(w_data[k]) for every k and increment the beat counter.
REQ-023 Cycles in ACC with in_valid low SHALL leave the accumulators and the counter unchanged.
REQ-024 After the n_in-th accepted beat, the FSM SHALL go to ACT; in_ready SHALL be 0 in every state except ACC.
REQ-025 In ACT, for a single cycle, the engine SHALL compute r[k] = acc[k] >>> (DW-1), saturate it to [-2^(DW-1), 2^(DW-1)-1], force negative values to 0 if relu_en was latched, register the result into out_data, and go to DONE.
REQ-026 out_valid SHALL be high throughout DONE, the state entered 2 cycles after the last input beat; out_data and argmax SHALL stay stable until out_valid and out_ready are both high, after which the FSM SHALL return to IDLE.
REQ-027 argmax SHALL use signed comparison, and on a tie SHALL report the lowest index.
REQ-028 A start asserted while busy SHALL be ignored, with no err pulse.
REQ-029 The accumulators SHALL never overflow, because the ACCW rule is enforced.

Reset
REQ-030 While rst is high, the FSM SHALL go to IDLE and the accumulators and counter SHALL be cleared, including mid-pass.
REQ-031 While rst is high, out_data, argmax, out_valid, in_ready, busy and err SHALL be 0.

Configuration
REQ-032 With the macro MLP_ARGMAX_EN defined, the argmax comparator tree SHALL be built and argmax SHALL be registered in ACT together with out_data.
REQ-033 Without MLP_ARGMAX_EN, no comparator logic SHALL be built and argmax SHALL be constant 0.

Verification
REQ-034 Scenario: n_in=1, bias=0, in_data=64, all weights 64 -> every out_data element = 32; out_valid rises 2 cycles after the beat.
REQ-035 Scenario: n_in=4, all in_data, weights and biases = 127 -> every element saturates to 127; with relu_en=0, n_in=1, in_data=64, weights=-64 -> every element = -32 (0xE0); with relu_en=1 -> every element = 0.
REQ-036 Scenario: in_valid toggled every other cycle over n_in=62 -> result identical to the back-to-back run; in_ready falls after beat 62.
REQ-037 Scenario: neurons 3 and 7 tie at the maximum -> argmax = 3 (MLP_ARGMAX_EN defined), argmax = 0 (macro undefined); out_ready held low for 5 cycles -> outputs stable throughout.
REQ-038 Scenario: start with n_in=0 -> err pulses once and busy stays 0; rst after beat 10 of 62 -> IDLE next cycle with all outputs 0, and a new pass then produces correct results.
